// File: rtl/bram18_pkg.sv
// Shared geometry for the 8-to-32 asymmetric block RAM: port widths, depths
// and the byte-lane index type used by the write decode.
package bram18_pkg;

   localparam int A_AW   = 11;
   localparam int A_DW   = 8;
   localparam int RATIO  = 4;
   localparam int LANE_W = $clog2(RATIO);
   localparam int B_AW   = A_AW - LANE_W;
   localparam int B_DW   = A_DW * RATIO;
   localparam int DEPTH  = 1 << B_AW;

   typedef logic [LANE_W-1:0] lane_t;
   typedef logic [B_AW-1:0]   word_addr_t;

   function automatic lane_t lane_of(input logic [A_AW-1:0] byte_addr);
      return byte_addr[LANE_W-1:0];
   endfunction

   function automatic word_addr_t word_of(input logic [A_AW-1:0] byte_addr);
      return byte_addr[A_AW-1:LANE_W];
   endfunction

endpackage

// File: rtl/bram18_8to32.sv
// Simple-dual-port RAM, 2048x8 write / 512x32 read, single clock, read-first.
// Define BRAM18_OUT_REG_EN to add a second output register (read latency 2).
module bram18_8to32
   import bram18_pkg::*;
(
   input  logic            clka,
   input  logic            rst,
   input  logic            ena,
   input  logic            wea,
   input  logic [A_AW-1:0] addra,
   input  logic [A_DW-1:0] dina,
   input  logic            enb,
   input  logic [B_AW-1:0] addrb,
   output logic [B_DW-1:0] doutb
);

   // Power-up contents are zero; tools map the declaration initializer to BRAM init.
   logic [B_DW-1:0] r_mem [0:DEPTH-1] = '{default: '0};

   word_addr_t       w_word_addr;
   lane_t            w_lane;
   logic [RATIO-1:0] w_byte_we;
   logic [B_DW-1:0]  r_rd_data;

   always_comb begin
      w_word_addr = word_of(addra);
      w_lane      = lane_of(addra);
      w_byte_we   = '0;
      if (ena && wea) begin
         w_byte_we[w_lane] = 1'b1;
      end
   end

   // NOTE: the array is deliberately excluded from rst so it still maps onto a
   // BRAM; only the read pipeline registers are cleared.
   always_ff @(posedge clka) begin
      for (int i = 0; i < RATIO; i++) begin
         if (w_byte_we[i]) begin
            r_mem[w_word_addr][i*A_DW +: A_DW] <= dina;
         end
      end
   end

   // NOTE: non-blocking updates make a same-cycle read see the pre-write word
   // (read-first), independent of the order of the two processes.
   always_ff @(posedge clka) begin
      if (rst) begin
         r_rd_data <= '0;
      end else if (enb) begin
         r_rd_data <= r_mem[addrb];
      end
   end

`ifdef BRAM18_OUT_REG_EN
   logic [B_DW-1:0] r_out_data;

   always_ff @(posedge clka) begin
      if (rst) begin
         r_out_data <= '0;
      end else if (enb) begin
         r_out_data <= r_rd_data;
      end
   end

   assign doutb = r_out_data;
`else
   assign doutb = r_rd_data;
`endif

endmodule

// File: tb/tb_bram18_8to32.sv
// Directed bench for bram18_8to32: zero init, byte-lane packing, enables,
// read-first collision, output hold and reset behaviour in either latency build.
module tb_bram18_8to32;
   import bram18_pkg::*;

`ifdef BRAM18_OUT_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic            clka = 1'b0;
   logic            rst;
   logic            ena;
   logic            wea;
   logic [A_AW-1:0] addra;
   logic [A_DW-1:0] dina;
   logic            enb;
   logic [B_AW-1:0] addrb;
   logic [B_DW-1:0] doutb;

   int n_tests = 0;
   int n_fail  = 0;

   bram18_8to32 dut (
      .clka  (clka),
      .rst   (rst),
      .ena   (ena),
      .wea   (wea),
      .addra (addra),
      .dina  (dina),
      .enb   (enb),
      .addrb (addrb),
      .doutb (doutb)
   );

   always #5 clka = ~clka;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   // Advance one edge; inputs change and outputs are sampled 1ns after it.
   task automatic tick();
      @(posedge clka);
      #1;
   endtask

   task automatic write_byte(input logic [A_AW-1:0] a, input logic [A_DW-1:0] d);
      ena   = 1'b1;
      wea   = 1'b1;
      addra = a;
      dina  = d;
      tick();
      ena   = 1'b0;
      wea   = 1'b0;
   endtask

   task automatic read_word(input string tag, input logic [B_AW-1:0] a, input logic [31:0] exp);
      enb   = 1'b1;
      addrb = a;
      repeat (LAT) tick();
      check(tag, doutb, exp);
   endtask

   initial begin
      logic [31:0] held;
      rst   = 1'b1;
      ena   = 1'b0;
      wea   = 1'b0;
      addra = '0;
      dina  = '0;
      enb   = 1'b1;
      addrb = '0;

      // Reset with enb high: rst wins
      repeat (2) tick();
      check("reset_dout", doutb, 32'h0);
      rst = 1'b0;
      read_word("zero_init", 9'h000, 32'h0);
      read_word("zero_init_top", 9'h1FF, 32'h0);

      // Byte packing, lowest address in bits [7:0]
      write_byte(11'h000, 8'h11);
      write_byte(11'h001, 8'h22);
      write_byte(11'h002, 8'h33);
      write_byte(11'h003, 8'h44);
      read_word("pack_word0", 9'h000, 32'h44332211);

      // Top of the address range
      write_byte(11'h7FF, 8'hAB);
      read_word("top_word", 9'h1FF, 32'hAB000000);
      check("top_byte_lane", {24'h0, doutb[31:24]}, 32'h000000AB);

      // Disabled writes leave memory untouched
      ena = 1'b0; wea = 1'b1; addra = 11'h004; dina = 8'hFF;
      tick();
      ena = 1'b1; wea = 1'b0; addra = 11'h005; dina = 8'hEE;
      tick();
      ena = 1'b0; wea = 1'b0;
      read_word("no_write", 9'h001, 32'h0);

      // Read-first collision on word 0
      ena = 1'b1; wea = 1'b1; addra = 11'h001; dina = 8'h99;
      enb = 1'b1; addrb = 9'h000;
      tick();
      ena = 1'b0; wea = 1'b0;
      repeat (LAT-1) tick();
      check("collision_old", doutb, 32'h44332211);
      read_word("collision_new", 9'h000, 32'h44339911);

      // enb=0 holds the output while addrb moves
      read_word("pre_hold", 9'h1FF, 32'hAB000000);
      enb = 1'b0;
      addrb = 9'h000;
      tick();
      check("hold_1", doutb, 32'hAB000000);
      addrb = 9'h001;
      repeat (2) tick();
      check("hold_2", doutb, 32'hAB000000);

      // Mid-stream reset clears output; a write during reset still lands
      rst = 1'b1; enb = 1'b1; addrb = 9'h000;
      ena = 1'b1; wea = 1'b1; addra = 11'h008; dina = 8'h5A;
      tick();
      ena = 1'b0; wea = 1'b0;
      check("rst_mid", doutb, 32'h0);
      rst = 1'b0; enb = 1'b0;
      tick();
      held = doutb;
      check("hold_after_rst", held, 32'h0);
      read_word("retained", 9'h000, 32'h44339911);
      read_word("write_in_rst", 9'h002, 32'h0000005A);
      read_word("top_retained", 9'h1FF, 32'hAB000000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
